// File: rtl/fetch_queue.sv
// Purpose: in-order instruction fetch queue between fetch and decode, with a flush on redirect.
// Latency: an entry pushed at edge N is visible on out_* after edge N; there is no in-to-out bypass.
// Backpressure: in_ready is low only when the queue is full; a pop cannot free a slot for a push in the same cycle.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push, pop;

    // in_ready and out_valid come from count_q alone, so neither handshake
    // depends combinationally on the other side or on flush.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign count     = count_q;

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is left uninitialised; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table for the corner cases, then random traffic against a queue model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] KEY   = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc;
    logic [$clog2(DEPTH):0] count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    typedef struct {
        logic        rst, iv, ordy, fl;
        logic [31:0] pc, instr;
        int          ecnt;
        logic        eov, eir;
        logic [31:0] epc, einstr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic iv, logic [31:0] pc, logic ordy, logic fl,
                                int ecnt, logic eov, logic [31:0] epc, logic eir);
        vec_t v;
        v.rst = r; v.iv = iv; v.pc = pc; v.instr = pc ^ KEY; v.ordy = ordy; v.fl = fl;
        v.ecnt = ecnt; v.eov = eov; v.eir = eir;
        v.epc    = eov ? epc : 32'h0;
        v.einstr = eov ? (epc ^ KEY) : NOP;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_outs(input string tag, input int ecnt, input logic eov,
                              input logic [31:0] epc, input logic [31:0] einstr, input logic eir);
        chk({tag, ".count"},     32'(count),     32'(ecnt));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, ".out_pc"},    out_pc,         epc);
        chk({tag, ".out_instr"}, out_instr,      einstr);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(eir));
    endtask

    logic [63:0] mq[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pc = '0; in_instr = '0;

        //            rst iv pc         or fl  cnt ov epc        ir
        vecs.push_back(mk(1, 0, 32'h0,   0, 0,  0, 0, 32'h0,   1)); // reset
        vecs.push_back(mk(0, 1, 32'h0,   0, 0,  1, 1, 32'h0,   1)); // first push, instr 00500093
        vecs.push_back(mk(0, 1, 32'h4,   0, 0,  2, 1, 32'h0,   1));
        vecs.push_back(mk(0, 1, 32'h8,   0, 0,  3, 1, 32'h0,   1));
        vecs.push_back(mk(0, 1, 32'hC,   0, 0,  4, 1, 32'h0,   0)); // full
        vecs.push_back(mk(0, 1, 32'h50,  0, 0,  4, 1, 32'h0,   0)); // ignored while full
        vecs.push_back(mk(0, 0, 32'h0,   1, 0,  3, 1, 32'h4,   1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0,  2, 1, 32'h8,   1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0,  1, 1, 32'hC,   1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0,  0, 0, 32'h0,   1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0,  0, 0, 32'h0,   1)); // pop on empty
        vecs.push_back(mk(0, 1, 32'h100, 0, 0,  1, 1, 32'h100, 1));
        vecs.push_back(mk(0, 1, 32'h104, 0, 0,  2, 1, 32'h100, 1));
        vecs.push_back(mk(0, 1, 32'h10,  1, 0,  2, 1, 32'h104, 1)); // steady push+pop across wrap
        vecs.push_back(mk(0, 1, 32'h14,  1, 0,  2, 1, 32'h10,  1));
        vecs.push_back(mk(0, 1, 32'h18,  1, 0,  2, 1, 32'h14,  1));
        vecs.push_back(mk(0, 1, 32'h1C,  1, 0,  2, 1, 32'h18,  1));
        vecs.push_back(mk(0, 1, 32'h20,  1, 0,  2, 1, 32'h1C,  1));
        vecs.push_back(mk(0, 1, 32'h24,  1, 0,  2, 1, 32'h20,  1));
        vecs.push_back(mk(0, 1, 32'h28,  0, 0,  3, 1, 32'h20,  1));
        vecs.push_back(mk(0, 1, 32'h2C,  1, 1,  0, 0, 32'h0,   1)); // flush beats push and pop
        vecs.push_back(mk(0, 1, 32'h30,  0, 0,  1, 1, 32'h30,  1));
        vecs.push_back(mk(0, 1, 32'h34,  0, 0,  2, 1, 32'h30,  1));
        vecs.push_back(mk(0, 1, 32'h38,  0, 0,  3, 1, 32'h30,  1));
        vecs.push_back(mk(0, 1, 32'h3C,  0, 0,  4, 1, 32'h30,  0));
        vecs.push_back(mk(0, 1, 32'h40,  1, 0,  3, 1, 32'h34,  1)); // full: pop does not enable push
        vecs.push_back(mk(0, 0, 32'h0,   1, 0,  2, 1, 32'h38,  1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0,  1, 1, 32'h3C,  1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0,  0, 0, 32'h0,   1)); // 0x40 was never stored
        vecs.push_back(mk(0, 1, 32'h200, 0, 0,  1, 1, 32'h200, 1));
        vecs.push_back(mk(0, 1, 32'h204, 0, 0,  2, 1, 32'h200, 1));
        vecs.push_back(mk(1, 1, 32'h208, 1, 0,  0, 0, 32'h0,   1)); // reset mid-operation
        vecs.push_back(mk(0, 1, 32'h100, 0, 0,  1, 1, 32'h100, 1));
        vecs.push_back(mk(1, 1, 32'h300, 1, 1,  0, 0, 32'h0,   1)); // reset with flush too

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_pc = vecs[i].pc;
            in_instr = vecs[i].instr; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            @(posedge clk); #1;
            check_outs($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].eov,
                       vecs[i].epc, vecs[i].einstr, vecs[i].eir);
        end

        // Random traffic against a plain queue model; the DUT is empty after the last vector.
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            int sz;
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc     = $urandom;
            in_instr  = $urandom;
            sz = mq.size();
            if (rst || flush) begin
                mq.delete();
            end else begin
                if (out_ready && sz > 0) void'(mq.pop_front());
                if (in_valid && sz < DEPTH) mq.push_back({in_pc, in_instr});
            end
            @(posedge clk); #1;
            if (mq.size() != 0)
                check_outs($sformatf("rnd%0d", c), mq.size(), 1'b1, mq[0][63:32], mq[0][31:0],
                           mq.size() < DEPTH);
            else
                check_outs($sformatf("rnd%0d", c), 0, 1'b0, 32'h0, NOP, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of entries; power of two, at least 2.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction presented while the queue is empty.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: in_valid  input  1  fetch stage presents an instruction.
REQ-006 Port: in_instr  input  32  fetched instruction word.
REQ-007 Port: in_pc  input  32  PC of in_instr.
REQ-008 Port: in_ready  output  1  queue accepts a push this cycle.
REQ-009 Port: out_valid  output  1  head entry is valid for decode.
REQ-010 Port: out_instr  output  32  head instruction, or NOP_INSTR when empty.
REQ-011 Port: out_pc  output  32  head PC, or 0 when empty.
REQ-012 Port: out_ready  input  1  decode consumes the head this cycle (decode not stalled).
REQ-013 Port: flush  input  1  branch/jump redirect; discard all queued and incoming entries.
REQ-014 Port: count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH {pc, instr} entries with rd_ptr, wr_ptr ($clog2(DEPTH) bits each) and count.
REQ-016 in_ready SHALL be (count < DEPTH); it SHALL NOT depend combinationally on out_ready, in_valid or flush.
REQ-017 out_valid SHALL be (count != 0), driven from registered state only.
REQ-018 out_instr/out_pc SHALL read entry[rd_ptr] when out_valid=1, and NOP_INSTR/0 otherwise.
REQ-019 Push SHALL occur when in_valid & in_ready & ~flush: entry[wr_ptr] <= {in_pc, in_instr}; wr_ptr increments.
REQ-020 Pop SHALL occur when out_valid & out_ready & ~flush: rd_ptr increments.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-022 count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-023 Latency: an entry pushed at edge N SHALL appear on out_* after edge N; there is no combinational in-to-out bypass.
REQ-024 Full: in_ready=0, so in_valid is ignored; a pop in the same cycle SHALL NOT enable a push in that cycle.
REQ-025 Empty: out_ready is ignored; count, rd_ptr and outputs SHALL be unchanged.
REQ-026 Flush SHALL take priority over push and pop; at the next edge count=0, rd_ptr=wr_ptr=0, and the cycle's in_* is dropped.
REQ-027 The cycle after a flush, in_ready=1 and out_valid=0.
REQ-028 Entries SHALL leave in exactly the order they were pushed; no entry is duplicated or skipped.
REQ-029 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-030 With rst=1 at a rising edge: count=0, rd_ptr=wr_ptr=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1.
REQ-031 rst SHALL override flush, push and pop in the same cycle; entry contents need not be cleared.
REQ-032 Reset mid-operation SHALL discard all queued entries; the first push after rst deasserts lands in entry 0.

Verification
REQ-033 Reset then push pc=0x0/instr=0x00500093 with out_ready=0 -> next cycle out_valid=1, out_pc=0, out_instr=0x00500093, count=1.
REQ-034 Push 4 entries (pc 0x0,0x4,0x8,0xC) with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is ignored; pop 4 yields pcs 0x0,0x4,0x8,0xC in order.
REQ-035 Hold count=2, then assert in_valid=out_ready=1 for 6 cycles with pcs 0x10..0x24 -> count stays 2 and outputs stay in order across pointer wrap.
REQ-036 count=3 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, out_instr=0x00000013, in_ready=1.
REQ-037 Full queue, out_ready=1 and in_valid=1 in the same cycle -> count=3 next cycle and the incoming entry is not stored.
REQ-038 rst=1 with count=2 and flush=0 -> next cycle count=0, out_pc=0; a following push pc=0x100 appears at the head one cycle later.
